alarm_ring_ctrl: RTL and testbench

//  Consumes the 64-bit alarm timestamp produced by the BCD-to-alarm-stamp stage and
//  the running second counter; arms, detects expiry, drives ringing/buzzer, handles

---
 rtl/alarm_ring_ctrl_if.sv | 32 +++
 rtl/alarm_ring_ctrl.sv | 127 ++++++++++++
 tb/tb_alarm_ring_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_ring_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : alarm_ring_ctrl_if
// Brief    : Stimulus/status bundle between the alarm-stamp converter, the
//            ring controller and the buzzer/LED drivers.
// Revision : 1.0 - initial release
// ============================================================================
interface alarm_ring_ctrl_if;
    logic        tick_1hz;
    logic [63:0] counter;
    logic [63:0] alarm_stamp;
    logic        alarm_en;
    logic        arm;
    logic        stop_btn;
    logic        snooze_btn;
    logic [1:0]  state;
    logic        ringing;
    logic        buzzer;
    logic        missed;
    logic [3:0]  snooze_cnt;

    modport master (
        output tick_1hz, counter, alarm_stamp, alarm_en, arm, stop_btn, snooze_btn,
        input  state, ringing, buzzer, missed, snooze_cnt
    );

    modport slave (
        input  tick_1hz, counter, alarm_stamp, alarm_en, arm, stop_btn, snooze_btn,
        output state, ringing, buzzer, missed, snooze_cnt
    );
endinterface
`default_nettype wire

// File: rtl/alarm_ring_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alarm_ring_ctrl
// Brief    : Arms on a 64-bit alarm stamp, rings on expiry, handles stop,
//            snooze, ring timeout and daily re-arm. All outputs registered.
// Revision : 1.0 - initial release
// ============================================================================
module alarm_ring_ctrl #(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_SECONDS = 300,
    parameter int MAX_SNOOZE     = 3,
    parameter int REPEAT_DAILY   = 1
) (
    input  logic              clk,
    input  logic              rst,
    alarm_ring_ctrl_if.slave  bus
);
    localparam int          RC_W          = $clog2(RING_SECONDS + 1);
    localparam logic [63:0] C_DAY_SECONDS = 64'd86400;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ARMED   = 2'b01,
        ST_RINGING = 2'b10,
        ST_SNOOZE  = 2'b11
    } state_t;

    state_t            state_q;
    logic [63:0]       base_q;
    logic [63:0]       target_q;
    logic [RC_W-1:0]   ring_cnt_q;
    logic              phase_q;
    logic              ringing_q;
    logic              buzzer_q;
    logic              missed_q;
    logic [3:0]        snooze_cnt_q;

    logic              w_snooze_ok;
    logic              w_timeout;
    logic              w_finish;
    logic              w_fire;
    logic [63:0]       w_next_base;

    assign w_snooze_ok = bus.snooze_btn && (snooze_cnt_q < 4'(MAX_SNOOZE));
    // A refused snooze does not mask the tick, so the timeout still counts.
    assign w_timeout   = (state_q == ST_RINGING) && !bus.stop_btn && !w_snooze_ok &&
                         bus.tick_1hz && (ring_cnt_q == RC_W'(RING_SECONDS - 1));
    assign w_finish    = (((state_q == ST_RINGING) || (state_q == ST_SNOOZE)) && bus.stop_btn) ||
                         w_timeout;
    assign w_fire      = (bus.counter >= target_q);
    assign w_next_base = base_q + C_DAY_SECONDS;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            base_q       <= '0;
            target_q     <= '0;
            ring_cnt_q   <= '0;
            phase_q      <= 1'b0;
            ringing_q    <= 1'b0;
            buzzer_q     <= 1'b0;
            missed_q     <= 1'b0;
            snooze_cnt_q <= '0;
        end else if (!bus.alarm_en) begin
            state_q   <= ST_IDLE;
            ringing_q <= 1'b0;
            buzzer_q  <= 1'b0;
        end else if (bus.arm) begin
            state_q      <= ST_ARMED;
            base_q       <= bus.alarm_stamp;
            target_q     <= bus.alarm_stamp;
            snooze_cnt_q <= '0;
            missed_q     <= 1'b0;
            ring_cnt_q   <= '0;
            phase_q      <= 1'b0;
            ringing_q    <= 1'b0;
            buzzer_q     <= 1'b0;
        end else if (w_finish) begin
            ringing_q <= 1'b0;
            buzzer_q  <= 1'b0;
            if (w_timeout) begin
                missed_q <= 1'b1;
            end
            if (REPEAT_DAILY != 0) begin
                base_q       <= w_next_base;
                target_q     <= w_next_base;
                snooze_cnt_q <= '0;
                state_q      <= ST_ARMED;
            end else begin
                state_q <= ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_ARMED, ST_SNOOZE: begin
                    if (w_fire) begin
                        state_q    <= ST_RINGING;
                        ring_cnt_q <= '0;
                        phase_q    <= 1'b0;
                        ringing_q  <= 1'b1;
                        buzzer_q   <= 1'b0;
                    end
                end
                ST_RINGING: begin
                    if (w_snooze_ok) begin
                        state_q      <= ST_SNOOZE;
                        target_q     <= bus.counter + 64'(SNOOZE_SECONDS);
                        snooze_cnt_q <= snooze_cnt_q + 4'd1;
                        ringing_q    <= 1'b0;
                        buzzer_q     <= 1'b0;
                    end else if (bus.tick_1hz) begin
                        ring_cnt_q <= ring_cnt_q + RC_W'(1);
                        phase_q    <= ~phase_q;
                        buzzer_q   <= ~phase_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.state      = state_q;
    assign bus.ringing    = ringing_q;
    assign bus.buzzer     = buzzer_q;
    assign bus.missed     = missed_q;
    assign bus.snooze_cnt = snooze_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_alarm_ring_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alarm_ring_ctrl
// Brief    : Self-checking bench: vector table, corner sequences and random
//            stimulus against a reference model, for daily and one-shot builds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alarm_ring_ctrl;
    localparam int              RS   = 60;
    localparam int              SNZ  = 300;
    localparam int              MAXS = 3;
    localparam longint unsigned DAY  = 64'd86400;
    localparam int M_IDLE = 0, M_ARMED = 1, M_RING = 2, M_SNZ = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick, en, arm, stop, snz;
    logic [63:0] counter, stamp;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    alarm_ring_ctrl_if bus1 ();
    alarm_ring_ctrl_if bus0 ();

    assign bus1.tick_1hz = tick;    assign bus0.tick_1hz = tick;
    assign bus1.counter = counter;  assign bus0.counter = counter;
    assign bus1.alarm_stamp = stamp; assign bus0.alarm_stamp = stamp;
    assign bus1.alarm_en = en;      assign bus0.alarm_en = en;
    assign bus1.arm = arm;          assign bus0.arm = arm;
    assign bus1.stop_btn = stop;    assign bus0.stop_btn = stop;
    assign bus1.snooze_btn = snz;   assign bus0.snooze_btn = snz;

    alarm_ring_ctrl #(.RING_SECONDS(RS), .SNOOZE_SECONDS(SNZ), .MAX_SNOOZE(MAXS),
                      .REPEAT_DAILY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    alarm_ring_ctrl #(.RING_SECONDS(RS), .SNOOZE_SECONDS(SNZ), .MAX_SNOOZE(MAXS),
                      .REPEAT_DAILY(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    typedef struct {
        int              st;
        bit              phase;
        bit              missed;
        int              scnt;
        longint unsigned base;
        longint unsigned target;
        int              rcnt;
    } mdl_t;

    mdl_t m [2];   // index = REPEAT_DAILY setting

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.st = M_IDLE; r.phase = 0; r.missed = 0; r.scnt = 0;
        r.base = 0; r.target = 0; r.rcnt = 0;
        return r;
    endfunction

    function automatic mdl_t mdl_step(mdl_t s, bit rep);
        mdl_t n;
        bit   fin;
        n   = s;
        fin = 0;
        if (!en) begin
            n.st = M_IDLE;
        end else if (arm) begin
            n.st = M_ARMED; n.base = stamp; n.target = stamp;
            n.scnt = 0; n.missed = 0; n.rcnt = 0; n.phase = 0;
        end else begin
            if (s.st == M_RING) begin
                if (stop) fin = 1;
                else if (snz && s.scnt < MAXS) begin
                    n.st = M_SNZ; n.target = counter + SNZ; n.scnt = s.scnt + 1;
                end else if (tick) begin
                    if (s.rcnt + 1 == RS) begin n.missed = 1; fin = 1; end
                    else begin n.rcnt = s.rcnt + 1; n.phase = !s.phase; end
                end
            end else if (s.st == M_SNZ && stop) begin
                fin = 1;
            end else if ((s.st == M_SNZ || s.st == M_ARMED) && counter >= s.target) begin
                n.st = M_RING; n.rcnt = 0; n.phase = 0;
            end
            if (fin) begin
                if (rep) begin
                    n.base = s.base + DAY; n.target = n.base; n.scnt = 0; n.st = M_ARMED;
                end else begin
                    n.st = M_IDLE;
                end
            end
        end
        return n;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic cmp_model();
        chk("d1_state",   64'(bus1.state),      64'(m[1].st));
        chk("d1_ringing", 64'(bus1.ringing),    64'(m[1].st == M_RING));
        chk("d1_buzzer",  64'(bus1.buzzer),     64'(m[1].st == M_RING && m[1].phase));
        chk("d1_missed",  64'(bus1.missed),     64'(m[1].missed));
        chk("d1_scnt",    64'(bus1.snooze_cnt), 64'(m[1].scnt));
        chk("d0_state",   64'(bus0.state),      64'(m[0].st));
        chk("d0_ringing", 64'(bus0.ringing),    64'(m[0].st == M_RING));
        chk("d0_buzzer",  64'(bus0.buzzer),     64'(m[0].st == M_RING && m[0].phase));
        chk("d0_missed",  64'(bus0.missed),     64'(m[0].missed));
        chk("d0_scnt",    64'(bus0.snooze_cnt), 64'(m[0].scnt));
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst) begin
            m[0] = mdl_reset(); m[1] = mdl_reset();
        end else begin
            m[0] = mdl_step(m[0], 1'b0); m[1] = mdl_step(m[1], 1'b1);
        end
        #1;
        cmp_model();
    endtask

    task automatic idle_inputs();
        tick = 0; arm = 0; stop = 0; snz = 0; en = 1;
    endtask

    typedef struct {
        bit en, arm, stop, snz, tick;
        longint unsigned cnt, stamp;
        int st;
        bit ring, buz, missed;
        int scnt;
    } vec_t;

    vec_t tbl[$];

    function automatic void addv(bit e, bit a, bit sp, bit sz, bit t, longint unsigned c,
                                 longint unsigned s, int st, bit r, bit b, bit mi, int sc);
        vec_t v;
        v.en = e; v.arm = a; v.stop = sp; v.snz = sz; v.tick = t; v.cnt = c; v.stamp = s;
        v.st = st; v.ring = r; v.buz = b; v.missed = mi; v.scnt = sc;
        tbl.push_back(v);
    endfunction

    initial begin
        m[0] = mdl_reset(); m[1] = mdl_reset();
        rst = 1; counter = 0; stamp = 0; idle_inputs();

        // Reset held with random inputs: outputs stay at reset values.
        for (int i = 0; i < 6; i++) begin
            en = 1'($urandom); arm = 1'($urandom); stop = 1'($urandom);
            snz = 1'($urandom); tick = 1'($urandom);
            counter = {$urandom, $urandom}; stamp = {$urandom, $urandom};
            cyc();
            chk("rst_state", 64'(bus1.state), 64'd0);
            chk("rst_outs", {59'd0, bus1.ringing, bus1.buzzer, bus1.missed, bus0.ringing, bus0.buzzer}, 64'd0);
            chk("rst_scnt", 64'(bus1.snooze_cnt), 64'd0);
        end
        idle_inputs(); counter = 0; stamp = 0;
        rst = 0;

        // en arm stop snz tick counter stamp | state ring buz missed scnt
        addv(1,1,0,0,0,   999, 1000, 1,0,0,0,0);
        addv(1,0,0,0,0,   999,    0, 1,0,0,0,0);
        addv(1,0,0,0,0,  1000,    0, 2,1,0,0,0);
        addv(1,0,0,0,1,  1001,    0, 2,1,1,0,0);
        addv(1,0,0,0,1,  1002,    0, 2,1,0,0,0);
        addv(1,0,0,0,1,  1003,    0, 2,1,1,0,0);
        addv(1,0,0,0,0,  1003,    0, 2,1,1,0,0);
        addv(1,0,0,0,1,  1004,    0, 2,1,0,0,0);
        addv(1,0,0,1,0,  1005,    0, 3,0,0,0,1);
        addv(1,0,0,0,0,  1304,    0, 3,0,0,0,1);
        addv(1,0,0,0,0,  1305,    0, 2,1,0,0,1);
        addv(1,0,0,1,0,  1305,    0, 3,0,0,0,2);
        addv(1,0,0,0,0,  1605,    0, 2,1,0,0,2);
        addv(1,0,0,1,0,  1605,    0, 3,0,0,0,3);
        addv(1,0,0,0,0,  1905,    0, 2,1,0,0,3);
        addv(1,0,0,1,0,  1905,    0, 2,1,0,0,3);
        addv(1,0,0,1,1,  1906,    0, 2,1,1,0,3);
        addv(1,0,1,0,0,  1906,    0, 1,0,0,0,0);
        addv(1,0,1,0,0, 87399,    0, 1,0,0,0,0);
        addv(1,0,0,1,0, 87399,    0, 1,0,0,0,0);
        addv(1,0,0,0,0, 87400,    0, 2,1,0,0,0);
        addv(0,0,0,0,0, 87400,    0, 0,0,0,0,0);
        addv(1,0,1,1,0, 87401,    0, 0,0,0,0,0);
        addv(1,1,0,0,0,   500, 1000, 1,0,0,0,0);
        addv(1,0,0,0,0,  5000,    0, 2,1,0,0,0);
        addv(1,1,1,0,0,  5000, 9000, 1,0,0,0,0);
        addv(1,0,0,0,0,  5001,    0, 1,0,0,0,0);
        addv(1,0,0,0,0,  9000,    0, 2,1,0,0,0);

        foreach (tbl[i]) begin
            en = tbl[i].en; arm = tbl[i].arm; stop = tbl[i].stop; snz = tbl[i].snz;
            tick = tbl[i].tick; counter = tbl[i].cnt; stamp = tbl[i].stamp;
            cyc();
            chk($sformatf("vec%0d_state", i), 64'(bus1.state), 64'(tbl[i].st));
            chk($sformatf("vec%0d_ring", i), 64'(bus1.ringing), 64'(tbl[i].ring));
            chk($sformatf("vec%0d_buz", i), 64'(bus1.buzzer), 64'(tbl[i].buz));
            chk($sformatf("vec%0d_missed", i), 64'(bus1.missed), 64'(tbl[i].missed));
            chk($sformatf("vec%0d_scnt", i), 64'(bus1.snooze_cnt), 64'(tbl[i].scnt));
        end
        idle_inputs();

        // Asynchronous reset while ringing: outputs clear without a clock edge.
        #1 rst = 1;
        #1;
        chk("async_rst_state", {62'd0, bus1.state}, 64'd0);
        chk("async_rst_ring_buz", {62'd0, bus1.ringing, bus1.buzzer}, 64'd0);
        m[0] = mdl_reset(); m[1] = mdl_reset();
        #1 rst = 0;

        // Unanswered ring times out after RS ticks.
        counter = 1000; stamp = 1000; arm = 1;
        cyc();
        arm = 0;
        cyc();
        chk("to_ringing", 64'(bus1.ringing), 64'd1);
        for (int i = 1; i < RS; i++) begin
            tick = 1; counter = counter + 1;
            cyc();
        end
        chk("to_before_state", 64'(bus1.state), 64'd2);
        chk("to_before_missed", 64'(bus1.missed), 64'd0);
        counter = counter + 1;
        cyc();
        tick = 0;
        chk("to_d1_state", 64'(bus1.state), 64'd1);
        chk("to_d1_missed", 64'(bus1.missed), 64'd1);
        chk("to_d0_state", 64'(bus0.state), 64'd0);
        chk("to_d0_missed", 64'(bus0.missed), 64'd1);
        counter = 87399;
        cyc();
        chk("rearm_wait", 64'(bus1.state), 64'd1);
        counter = 87400;
        cyc();
        chk("rearm_fire", 64'(bus1.state), 64'd2);
        chk("rearm_d0_idle", 64'(bus0.state), 64'd0);
        stamp = 100000; arm = 1;
        cyc();
        arm = 0;
        chk("arm_clears_missed", {62'd0, bus1.missed, bus0.missed}, 64'd0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 4000; i++) begin
            rst  = ($urandom_range(599) == 0);
            en   = ($urandom_range(99) != 0);
            arm  = ($urandom_range(39) == 0);
            stop = ($urandom_range(29) == 0);
            snz  = ($urandom_range(11) == 0);
            tick = ($urandom_range(2) == 0);
            if (tick) counter = counter + 1;
            if ($urandom_range(199) == 0) counter = counter + 64'($urandom_range(2000));
            if ($urandom_range(999) == 0) counter = {$urandom, $urandom};
            stamp = counter + 64'($urandom_range(30));
            if ($urandom_range(49) == 0) stamp = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(100));
            cyc();
        end
        rst = 0; idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
